// File: rtl/psk_qam_mapper_if.sv
// Sample-side and bit-side handshake bundle for psk_qam_mapper.
// The slave modport is the mapper itself; the master modport is whatever feeds it and drains it.
interface psk_qam_mapper_if #(
  parameter int OUT_W = 12
);
  logic [1:0]              mode;
  logic                    in_bit;
  logic                    in_valid;
  logic                    in_ready;
  logic                    out_ready;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_i;
  logic signed [OUT_W-1:0] out_q;
  logic                    sym_start;

  modport slave (
    input  mode,
    input  in_bit,
    input  in_valid,
    output in_ready,
    input  out_ready,
    output out_valid,
    output out_i,
    output out_q,
    output sym_start
  );

  modport master (
    output mode,
    output in_bit,
    output in_valid,
    input  in_ready,
    output out_ready,
    input  out_valid,
    input  out_i,
    input  out_q,
    input  sym_start
  );
endinterface

// File: rtl/psk_qam_mapper.sv
// Bit-serial BPSK/QPSK constellation mapper with registered signed I/Q output.
// Define QAM16_EN to add Gray-coded 16-QAM on mode 2; otherwise mode 2 maps as QPSK.
module psk_qam_mapper #(
  parameter int OUT_W    = 12,
  parameter int AMPL_PSK = 1447,
  parameter int AMPL_Q16 = 482
) (
  input logic             clk,
  input logic             rst_n,
  psk_qam_mapper_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

`ifdef QAM16_EN
  localparam int CNT_W = 2;
  localparam int SR_W  = 3;
`else
  localparam int CNT_W = 1;
  localparam int SR_W  = 1;
`endif

  localparam logic signed [OUT_W-1:0] P_PSK = OUT_W'(AMPL_PSK);
  localparam logic signed [OUT_W-1:0] N_PSK = -P_PSK;

  // Amplitudes must fit the positive range of the signed output.
  if (AMPL_PSK >= 2 ** (OUT_W - 1)) begin : g_bad_psk
    $error("psk_qam_mapper: AMPL_PSK does not fit OUT_W");
  end
  if (3 * AMPL_Q16 >= 2 ** (OUT_W - 1)) begin : g_bad_q16
    $error("psk_qam_mapper: 3*AMPL_Q16 does not fit OUT_W");
  end

  logic [CNT_W-1:0]        r_bit_cnt;
  logic [SR_W-1:0]         r_sr;
  mode_e                   r_mode;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_i;
  logic signed [OUT_W-1:0] r_out_q;

  mode_e                   w_act_mode;
  logic [CNT_W-1:0]        w_last_cnt;
  logic                    w_last;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_complete;
  logic signed [OUT_W-1:0] w_map_i;
  logic signed [OUT_W-1:0] w_map_q;

`ifdef QAM16_EN
  localparam logic signed [OUT_W-1:0] P_Q16_IN  = OUT_W'(AMPL_Q16);
  localparam logic signed [OUT_W-1:0] P_Q16_OUT = OUT_W'(3 * AMPL_Q16);

  function automatic logic signed [OUT_W-1:0] q16_level(input logic [1:0] g);
    case (g)
      2'b00:   q16_level = P_Q16_OUT;
      2'b01:   q16_level = P_Q16_IN;
      2'b11:   q16_level = -P_Q16_IN;
      default: q16_level = -P_Q16_OUT;
    endcase
  endfunction
`endif

  // On the first bit of a symbol the live mode input is the one that counts.
  always_comb begin
    w_act_mode = (r_bit_cnt == '0) ? mode_e'(bus.mode) : r_mode;
    case (w_act_mode)
      MODE_BPSK:  w_last_cnt = CNT_W'(0);
`ifdef QAM16_EN
      MODE_QAM16: w_last_cnt = CNT_W'(3);
`endif
      default:    w_last_cnt = CNT_W'(1);
    endcase
  end

  assign w_last     = (r_bit_cnt == w_last_cnt);
  assign w_in_ready = ~w_last | ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_complete = w_accept & w_last;

  // sr is oldest-bit-first toward the MSB, so the live bit is always the final one.
  always_comb begin
    w_map_i = '0;
    w_map_q = '0;
    case (w_act_mode)
      MODE_BPSK: begin
        w_map_i = bus.in_bit ? N_PSK : P_PSK;
        w_map_q = '0;
      end
`ifdef QAM16_EN
      MODE_QAM16: begin
        w_map_i = q16_level(r_sr[2:1]);
        w_map_q = q16_level({r_sr[0], bus.in_bit});
      end
`endif
      default: begin
        w_map_i = r_sr[0]    ? N_PSK : P_PSK;
        w_map_q = bus.in_bit ? N_PSK : P_PSK;
      end
    endcase
  end

  // A completing symbol reloads the output even while the old one drains, so there is no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_sr        <= '0;
      r_mode      <= MODE_QPSK;
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (r_bit_cnt == '0) begin
          r_mode <= mode_e'(bus.mode);
        end
        if (w_complete) begin
          r_bit_cnt   <= '0;
          r_out_i     <= w_map_i;
          r_out_q     <= w_map_q;
          r_out_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
`ifdef QAM16_EN
          r_sr      <= {r_sr[1:0], bus.in_bit};
`else
          r_sr      <= bus.in_bit;
`endif
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_i     = r_out_i;
  assign bus.out_q     = r_out_q;
  assign bus.sym_start = (r_bit_cnt == '0);

endmodule
